// File: rtl/fetch_stage.sv
// Instruction fetch with a single-outstanding imem handshake, a one-entry skid buffer and the IF/ID register.
// Latency: a response delivers to IF/ID on the next edge. The next request issues the cycle after that.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DISCARD} state_t;

  state_t      state, state_next;
  logic [31:0] req_pc;
  logic [31:0] skid_instr;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        accept;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic        capture;
  logic [31:0] pc_next;
  logic [31:0] req_pc_plus4;

  assign redirect     = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
  assign redirect_pc  = (PCSrcE == 2'b01) ? PCTargetE : (ALUResultE & ~32'd1);
  assign imem_req     = !rst && (state == S_FETCH) && !StallF;
  assign imem_addr    = PCF;
  assign accept       = imem_req && imem_ready;
  assign req_pc_plus4 = req_pc + 32'd4;

  always_comb begin
    state_next    = state;
    pc_next       = PCF;
    deliver       = 1'b0;
    deliver_instr = skid_instr;
    capture       = 1'b0;
    case (state)
      S_FETCH: begin
        if (accept) state_next = redirect ? S_DISCARD : S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          state_next = imem_rvalid ? S_FETCH : S_DISCARD;
        end else if (imem_rvalid) begin
          if (StallD) begin
            capture    = 1'b1;
            state_next = S_HOLD;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            pc_next       = req_pc_plus4;
            state_next    = S_FETCH;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_next = S_FETCH;
        end else if (!StallD) begin
          deliver    = 1'b1;
          pc_next    = req_pc_plus4;
          state_next = S_FETCH;
        end
      end
      default: begin
        if (imem_rvalid) state_next = S_FETCH;
      end
    endcase
    // Redirect wins over sequential PC advance in every state.
    if (redirect) pc_next = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      PCF        <= RESET_PC;
      req_pc     <= RESET_PC;
      skid_instr <= NOP_INSTR;
    end else begin
      state <= state_next;
      PCF   <= pc_next;
      if (accept) req_pc <= PCF;
      if (capture) skid_instr <= imem_rdata;
    end
  end

  // IF/ID register: flush beats stall, stall beats delivery/bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (deliver) begin
        InstrD   <= deliver_instr;
        PCD      <= req_pc;
        PCPlus4D <= req_pc_plus4;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory responses are driven by hand step by step.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE, ALUResultE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int checks   = 0;
  int failures = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] pc4, input logic vld);
    chk({tag, "_instr"}, InstrD, instr);
    chk({tag, "_pcd"}, PCD, pc);
    chk({tag, "_pc4"}, PCPlus4D, pc4);
    chk({tag, "_valid"}, {31'd0, ValidD}, {31'd0, vld});
  endtask

  initial begin
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 2'b00; PCTargetE = 32'd0; ALUResultE = 32'd0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;

    // Reset
    tick; tick;
    chk("rst_pcf", PCF, 32'hBFC00000);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    ifid("rst", 32'h00000013, 32'd0, 32'd0, 1'b0);
    rst = 1'b0;
    #1;
    chk("f0_req", {31'd0, imem_req}, 32'd1);
    chk("f0_addr", imem_addr, 32'hBFC00000);

    // Two sequential fetches with 1-cycle memory
    tick;
    chk("w0_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h00500093;
    tick;
    imem_rvalid = 1'b0;
    ifid("d0", 32'h00500093, 32'hBFC00000, 32'hBFC00004, 1'b1);
    chk("d0_pcf", PCF, 32'hBFC00004);
    chk("d0_addr", imem_addr, 32'hBFC00004);
    tick;
    ifid("bub0", 32'h00000013, 32'hBFC00000, 32'hBFC00004, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'h00100113;
    tick;
    imem_rvalid = 1'b0;
    ifid("d1", 32'h00100113, 32'hBFC00004, 32'hBFC00008, 1'b1);
    chk("d1_pcf", PCF, 32'hBFC00008);

    // Response under StallD lands in the skid buffer
    tick;
    StallD = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h00208193;
    tick;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      ifid("hold", 32'h00000013, 32'hBFC00004, 32'hBFC00008, 1'b0);
      chk("hold_pcf", PCF, 32'hBFC00008);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      if (i < 2) tick;
    end
    StallD = 1'b0;
    tick;
    ifid("hd", 32'h00208193, 32'hBFC00008, 32'hBFC0000C, 1'b1);
    chk("hd_pcf", PCF, 32'hBFC0000C);
    chk("hd_addr", imem_addr, 32'hBFC0000C);

    // Branch redirect while waiting: stale response is dropped
    tick;
    PCSrcE = 2'b01; PCTargetE = 32'hBFC00040; FlushD = 1'b1;
    tick;
    PCSrcE = 2'b00; FlushD = 1'b0;
    chk("br_pcf", PCF, 32'hBFC00040);
    chk("br_valid", {31'd0, ValidD}, 32'd0);
    chk("br_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick;
    imem_rvalid = 1'b0;
    chk("br_drop_instr", InstrD, 32'h00000013);
    chk("br_drop_valid", {31'd0, ValidD}, 32'd0);
    chk("br_addr", imem_addr, 32'hBFC00040);
    chk("br_req2", {31'd0, imem_req}, 32'd1);

    // JALR redirect coinciding with a response
    tick;
    PCSrcE = 2'b10; ALUResultE = 32'hBFC00081;
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFEBABE;
    tick;
    PCSrcE = 2'b00; imem_rvalid = 1'b0;
    chk("jr_addr", imem_addr, 32'hBFC00080);
    chk("jr_instr", InstrD, 32'h00000013);
    chk("jr_valid", {31'd0, ValidD}, 32'd0);
    chk("jr_req", {31'd0, imem_req}, 32'd1);

    // StallF holds off requests
    StallF = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("sf_req", {31'd0, imem_req}, 32'd0);
      chk("sf_pcf", PCF, 32'hBFC00080);
      tick;
    end
    StallF = 1'b0;
    #1;
    chk("sf_rel_req", {31'd0, imem_req}, 32'd1);
    chk("sf_rel_addr", imem_addr, 32'hBFC00080);

    // Reset while a request is outstanding
    tick;
    rst = 1'b1;
    tick;
    chk("mr_pcf", PCF, 32'hBFC00000);
    chk("mr_instr", InstrD, 32'h00000013);
    chk("mr_valid", {31'd0, ValidD}, 32'd0);
    chk("mr_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;

    // PC wrap at the top of the address space
    StallF = 1'b1; PCSrcE = 2'b01; PCTargetE = 32'hFFFFFFFC;
    tick;
    StallF = 1'b0; PCSrcE = 2'b00;
    #1;
    chk("wr_addr", imem_addr, 32'hFFFFFFFC);
    chk("wr_req", {31'd0, imem_req}, 32'd1);
    tick;
    imem_rvalid = 1'b1; imem_rdata = 32'h00000033;
    tick;
    imem_rvalid = 1'b0;
    ifid("wr", 32'h00000033, 32'hFFFFFFFC, 32'h00000000, 1'b1);
    chk("wr_pcf", PCF, 32'h00000000);

    // FlushD cancels a delivery but PCF still advances
    tick;
    FlushD = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h11111111;
    tick;
    FlushD = 1'b0; imem_rvalid = 1'b0;
    chk("fl_instr", InstrD, 32'h00000013);
    chk("fl_valid", {31'd0, ValidD}, 32'd0);
    chk("fl_pcf", PCF, 32'h00000004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
